spart_host_ctrl: RTL and testbench
==================================

// Module: spart_host_ctrl
// PURPOSE
//  Bus master for one spart: drives its iocs/iorw/ioaddr/databus processor port.
//  After reset it programs the baud divisor, then arbitrates the single bus
//  between a TX byte stream (valid/ready) and RX draining into a local FIFO.
//  Replaces the processor as the sequencer of the spart register interface.
// PARAMETERS
//  CLK_FREQ   50_000_000  system clock Hz; divisor = CLK_FREQ/(16*baud) - 1, integer truncation
//  RX_DEPTH   4           RX FIFO entries, power of 2, >= 2
// PORTS
//  clk        in   1   system clock, rising edge
//  rst        in   1   asynchronous, active-high reset
//  baud_sel   in   2   00=4800 01=9600 10=19200 11=38400 (50 MHz: 0x28A/0x144/0x0A1/0x050)
//  tx_valid   in   1   tx_data holds a byte to send
//  tx_data    in   8   byte to transmit
//  tx_ready   out  1   byte accepted this cycle (valid & ready = transfer)
//  rx_valid   out  1   RX FIFO not empty
//  rx_data    out  8   RX FIFO head, stable while rx_valid and not popped
//  rx_ready   in   1   pop head when rx_valid
//  cfg_done   out  1   divisor programmed for current baud_sel
//  iocs       out  1   spart chip select
//  iorw       out  1   1=read, 0=write
//  ioaddr     out  2   00 TX/RX buffer, 01 status, 10 DB low, 11 DB high
//  databus    inout 8  driven only in write cycles, else 'z
//  rda        in   1   spart receive data available
//  tbr        in   1   spart transmit buffer ready
// BEHAVIOUR
//  Reset values: iocs=0 iorw=1 ioaddr=00 databus=z tx_ready=0 rx_valid=0 cfg_done=0; FIFO empty; state CFG_LO.
//  All bus outputs registered; every access is exactly one cycle with iocs=1.
//  FSM: CFG_LO -> CFG_HI -> GAP -> IDLE; IDLE -> RX_RD | TX_WR | CFG_LO; RX_RD/TX_WR -> GAP -> IDLE.
//   CFG_LO: write divisor[7:0] to ioaddr 10.  CFG_HI: write divisor[15:8] to ioaddr 11; cfg_done=1 from next cycle.
//   GAP: iocs=0 one cycle so rda/tbr reflect the previous access before the next decision.
//   IDLE: baud_sel != latched value -> cfg_done=0, latch baud_sel, go CFG_LO (highest priority).
//    Else rx_req = rda & FIFO not full; tx_req = tx_valid & tbr.
//    Both asserted: round-robin, the side not served last wins; after reset RX is favoured.
//   RX_RD: iocs=1 iorw=1 ioaddr=00; databus sampled at end of cycle, pushed to FIFO.
//   TX_WR: iocs=1 iorw=0 ioaddr=00 databus=tx_data; tx_ready=1 this cycle only.
//  tx_ready is 1 only in TX_WR; tx_data must stay stable while tx_valid and not accepted.
//  FIFO: push+pop same cycle -> count unchanged; full -> rda ignored, byte stays in spart (no loss here).
//  Pop when empty ignored. Pointers wrap modulo RX_DEPTH; count width clog2(RX_DEPTH)+1.
//  baud_sel change mid-access: the access completes; reconfiguration starts at next IDLE.
//  rst asserted mid-operation: immediate return to reset values; FIFO contents discarded.
//  Status register (ioaddr 01) is never read; rda/tbr are used directly.
// CONFIGURATION
//  SPART_ECHO_EN defined: each byte read in RX_RD is also set pending in an echo register.
//   Pending echo is written (TX_WR with echo byte, tx_ready stays 0) when tbr=1, ahead of tx_valid and RX.
//   While echo pending, no RX_RD is started. Echoed byte is still pushed to the FIFO.
//  Not defined: no echo register; TX traffic comes only from tx_valid/tx_data.
// TESTING
//  1 Reset release, baud_sel=01 -> writes 0x44@10 then 0x01@11, cfg_done=1 on cycle 3.
//  2 tbr=1, tx_valid with 0xA5 -> TX_WR with databus=0xA5 and ioaddr=00 iorw=0; tx_ready one cycle; next access >=2 cycles later.
//  3 Bus model returns 0x3C, 0x7E on rda -> rx_data 0x3C then 0x7E in order; 5th byte with RX_DEPTH=4 and no pop -> no RX_RD until pop.
//  4 rda=1 and tx_valid=1 tbr=1 held -> accesses alternate RX_RD, TX_WR, RX_RD..., each separated by GAP.
//  5 baud_sel 01->11 while idle -> cfg_done=0, writes 0x50@10 and 0x00@11, cfg_done=1; mid-TX change completes TX first.
//  6 SPART_ECHO_EN, rx byte 0x55 with tbr=1 -> TX_WR of 0x55 precedes pending tx_valid byte; tx_ready low during echo.

Source files
------------

// File: rtl/spart_host_ctrl.sv
// spart_host_ctrl: sequences one spart's register port (divisor setup, TX writes, RX draining into a FIFO).
// Build option SPART_ECHO_EN: every received byte is also written back out, ahead of other traffic.
module spart_host_ctrl #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int RX_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] baud_sel,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       cfg_done,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  input  logic       rda,
  input  logic       tbr
);

  localparam int AW = $clog2(RX_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0] DIV_4800  = 16'(CLK_FREQ / (16 * 4800) - 1);
  localparam logic [15:0] DIV_9600  = 16'(CLK_FREQ / (16 * 9600) - 1);
  localparam logic [15:0] DIV_19200 = 16'(CLK_FREQ / (16 * 19200) - 1);
  localparam logic [15:0] DIV_38400 = 16'(CLK_FREQ / (16 * 38400) - 1);

  function automatic logic [15:0] divisor(input logic [1:0] sel);
    case (sel)
      2'b00:   return DIV_4800;
      2'b01:   return DIV_9600;
      2'b10:   return DIV_19200;
      default: return DIV_38400;
    endcase
  endfunction

  typedef enum logic [2:0] {CFG_LO, CFG_HI, GAP, IDLE, RX_RD, TX_WR} state_t;
  state_t state, state_nxt;

  logic [1:0]    baud_lat;
  logic [15:0]   div_sel, div_lat;
  logic          last_rx, pick_rx, pick_tx, rx_req, tx_req, baud_chg;
  logic [7:0]    dout, tx_byte;
  logic          tx_own, echo_go, echo_pend;
  logic [7:0]    mem [RX_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, push, pop;

  assign div_sel  = divisor(baud_sel);
  assign div_lat  = divisor(baud_lat);
  assign full     = (count == CW'(RX_DEPTH));
  assign push     = iocs & iorw & ~full;
  assign pop      = rx_ready & rx_valid;
  assign rx_valid = (count != '0);
  assign rx_data  = mem[rd_ptr];
  assign databus  = (iocs & ~iorw) ? dout : 'z;
  assign baud_chg = (baud_sel != baud_lat);
  assign rx_req   = rda & ~full & ~echo_pend;
  assign tx_req   = tx_valid & tbr;

`ifdef SPART_ECHO_EN
  logic [7:0] echo_byte;
  logic       echo_sel;

  assign echo_go = echo_pend & tbr;
  assign tx_byte = echo_sel ? echo_byte : tx_data;
  assign tx_own  = ~echo_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      echo_pend <= 1'b0;
      echo_byte <= 8'h00;
      echo_sel  <= 1'b0;
    end else begin
      if (state == IDLE) echo_sel <= echo_go & ~baud_chg;
      if (push) begin
        echo_pend <= 1'b1;
        echo_byte <= databus;
      end else if (state == TX_WR && echo_sel) begin
        echo_pend <= 1'b0;
      end
    end
  end
`else
  assign echo_go   = 1'b0;
  assign echo_pend = 1'b0;
  assign tx_byte   = tx_data;
  assign tx_own    = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= CFG_LO;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output; otherwise a latch is inferred.
    state_nxt = state;
    pick_rx   = 1'b0;
    pick_tx   = 1'b0;
    case (state)
      CFG_LO:       state_nxt = CFG_HI;
      CFG_HI:       state_nxt = GAP;
      RX_RD, TX_WR: state_nxt = GAP;
      GAP:          state_nxt = IDLE;
      IDLE: begin
        if (baud_chg) begin
          state_nxt = CFG_LO;
        end else if (echo_go) begin
          state_nxt = TX_WR;
        end else if (rx_req && (!tx_req || !last_rx)) begin
          state_nxt = RX_RD;
          pick_rx   = 1'b1;
        end else if (tx_req) begin
          state_nxt = TX_WR;
          pick_tx   = 1'b1;
        end
      end
      default:      state_nxt = CFG_LO;
    endcase
  end

  // Bus outputs are loaded from the current state, so each access appears on the pins one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iocs     <= 1'b0;
      iorw     <= 1'b1;
      ioaddr   <= 2'b00;
      dout     <= 8'h00;
      tx_ready <= 1'b0;
      cfg_done <= 1'b0;
      baud_lat <= 2'b00;
      last_rx  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      iocs     <= 1'b0;
      iorw     <= 1'b1;
      ioaddr   <= 2'b00;
      tx_ready <= 1'b0;
      if (iocs && !iorw && ioaddr == 2'b11) cfg_done <= 1'b1;
      case (state)
        CFG_LO: begin
          iocs     <= 1'b1;
          iorw     <= 1'b0;
          ioaddr   <= 2'b10;
          dout     <= div_sel[7:0];
          baud_lat <= baud_sel;
        end
        CFG_HI: begin
          iocs   <= 1'b1;
          iorw   <= 1'b0;
          ioaddr <= 2'b11;
          dout   <= div_lat[15:8];
        end
        IDLE: begin
          if (baud_chg)     cfg_done <= 1'b0;
          else if (pick_rx) last_rx  <= 1'b1;
          else if (pick_tx) last_rx  <= 1'b0;
        end
        RX_RD: iocs <= 1'b1;
        TX_WR: begin
          iocs     <= 1'b1;
          iorw     <= 1'b0;
          dout     <= tx_byte;
          tx_ready <= tx_own;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // NOTE: storage is not reset; count and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= databus;
  end

endmodule

// File: tb/tb_spart_host_ctrl.sv
// Directed bench for spart_host_ctrl: a small spart bus model feeds RX bytes and logs every access.
module tb_spart_host_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] baud_sel = 2'b01;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       rx_ready = 1'b0;
  logic       tbr = 1'b0;
  wire        tx_ready, rx_valid, cfg_done, iocs, iorw, rda;
  wire  [7:0] rx_data;
  wire  [1:0] ioaddr;
  wire  [7:0] databus;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_src [32];
  int rx_head = 0;
  int rx_tail = 0;
  logic rd_prev = 1'b0;

  typedef struct {
    logic       rw;
    logic [1:0] addr;
    logic [7:0] data;
    logic       txr;
    int         cyc;
  } acc_t;
  acc_t acc_log [256];
  int log_n = 0;
  int cyc_n = 0;

  assign rda     = (rx_head != rx_tail);
  assign databus = (iocs && iorw) ? rx_src[rx_head[4:0]] : 8'bz;

  always #5 clk = ~clk;

  spart_host_ctrl #(.CLK_FREQ(50_000_000), .RX_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .baud_sel(baud_sel),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .cfg_done(cfg_done), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
    .databus(databus), .rda(rda), .tbr(tbr)
  );

  // Bus model: a read consumes the head byte, so rda drops before the next decision.
  always @(negedge clk) begin
    cyc_n++;
    if (rd_prev && rx_head != rx_tail) rx_head++;
    rd_prev = iocs && iorw;
    if (iocs && log_n < 256) begin
      acc_log[log_n] = '{iorw, ioaddr, databus, tx_ready, cyc_n};
      log_n++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push_rx(input logic [7:0] b);
    rx_src[rx_tail[4:0]] = b;
    rx_tail++;
  endtask

  task automatic wait_log(input int n, input int budget, output bit ok);
    ok = (log_n >= n);
    for (int i = 0; i < budget && !ok; i++) begin
      tick(1);
      ok = (log_n >= n);
    end
  endtask

  task automatic wait_txr(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick(1);
      ok = (tx_ready === 1'b1);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(2);
    checks++; if (iocs !== 1'b0)     begin errors++; $display("FAIL rst_iocs got %b exp 0", iocs); end
    checks++; if (iorw !== 1'b1)     begin errors++; $display("FAIL rst_iorw got %b exp 1", iorw); end
    checks++; if (ioaddr !== 2'b00)  begin errors++; $display("FAIL rst_ioaddr got %b exp 00", ioaddr); end
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL rst_tx_ready got %b exp 0", tx_ready); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rst_rx_valid got %b exp 0", rx_valid); end
    checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL rst_cfg_done got %b exp 0", cfg_done); end
  endtask

  task automatic test_config;
    rst = 1'b0;
    tick(1);
    checks++; if ({iocs, iorw, ioaddr} !== 4'b1010) begin errors++; $display("FAIL cfg1_ctl got %b exp 1010", {iocs, iorw, ioaddr}); end
    checks++; if (databus !== 8'h44) begin errors++; $display("FAIL cfg1_data got %h exp 44", databus); end
    checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL cfg1_done got %b exp 0", cfg_done); end
    tick(1);
    checks++; if ({iocs, iorw, ioaddr} !== 4'b1011) begin errors++; $display("FAIL cfg2_ctl got %b exp 1011", {iocs, iorw, ioaddr}); end
    checks++; if (databus !== 8'h01) begin errors++; $display("FAIL cfg2_data got %h exp 01", databus); end
    checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL cfg2_done got %b exp 0", cfg_done); end
    tick(1);
    checks++; if (iocs !== 1'b0)     begin errors++; $display("FAIL cfg3_iocs got %b exp 0", iocs); end
    checks++; if (cfg_done !== 1'b1) begin errors++; $display("FAIL cfg3_done got %b exp 1", cfg_done); end
  endtask

  task automatic test_tx;
    bit ok;
    int start, c0;
    start = log_n;
    tbr = 1'b1;
    tx_data = 8'hA5;
    tx_valid = 1'b1;
    wait_txr(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL tx_timeout got no tx_ready exp tx_ready"); end
    checks++; if ({iocs, iorw, ioaddr} !== 4'b1000) begin errors++; $display("FAIL tx_ctl got %b exp 1000", {iocs, iorw, ioaddr}); end
    checks++; if (databus !== 8'hA5) begin errors++; $display("FAIL tx_data got %h exp a5", databus); end
    c0 = cyc_n;
    tx_data = 8'h5A;
    tick(1);
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL tx_ready_pulse got %b exp 0", tx_ready); end
    wait_txr(20, ok);
    checks++; if (!ok || cyc_n - c0 < 3) begin errors++; $display("FAIL tx_spacing got %0d exp >=3", cyc_n - c0); end
    checks++; if (databus !== 8'h5A) begin errors++; $display("FAIL tx_data2 got %h exp 5a", databus); end
    tx_valid = 1'b0;
    tick(10);
    checks++; if (log_n !== start + 2) begin errors++; $display("FAIL tx_count got %0d exp %0d", log_n - start, 2); end
  endtask

  task automatic test_rx;
    tbr = 1'b0;
    push_rx(8'h3C);
    push_rx(8'h7E);
    tick(20);
    checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h3C) begin errors++; $display("FAIL rx_first got %b/%h exp 1/3c", rx_valid, rx_data); end
    rx_ready = 1'b1; tick(1); rx_ready = 1'b0;
    checks++; if (rx_data !== 8'h7E) begin errors++; $display("FAIL rx_second got %h exp 7e", rx_data); end
    rx_ready = 1'b1; tick(1); rx_ready = 1'b0;
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rx_empty got %b exp 0", rx_valid); end
    for (int i = 0; i < 5; i++) push_rx(8'(8'h11 + i));
    tick(40);
    checks++; if (rx_tail - rx_head !== 1) begin errors++; $display("FAIL rx_full_hold got %0d left exp 1", rx_tail - rx_head); end
    checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL rx_full_head got %h exp 11", rx_data); end
    rx_ready = 1'b1; tick(1); rx_ready = 1'b0;
    tick(20);
    checks++; if (rx_tail !== rx_head) begin errors++; $display("FAIL rx_resume got %0d left exp 0", rx_tail - rx_head); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rx_valid !== 1'b1 || rx_data !== 8'(8'h12 + i)) begin errors++; $display("FAIL rx_drain%0d got %b/%h exp 1/%h", i, rx_valid, rx_data, 8'(8'h12 + i)); end
      rx_ready = 1'b1; tick(1); rx_ready = 1'b0;
    end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rx_drained got %b exp 0", rx_valid); end
    rx_ready = 1'b1; tick(2); rx_ready = 1'b0;
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rx_pop_empty got %b exp 0", rx_valid); end
    push_rx(8'h77);
    tick(10);
    checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h77) begin errors++; $display("FAIL rx_after_empty got %b/%h exp 1/77", rx_valid, rx_data); end
    rx_ready = 1'b1; tick(1); rx_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    bit ok;
    int start;
    start = log_n;
    rx_ready = 1'b1;
    tx_data = 8'hC3;
    for (int i = 0; i < 4; i++) push_rx(8'(8'hA0 + i));
    tbr = 1'b1;
    tx_valid = 1'b1;
    wait_log(start + 4, 100, ok);
    tx_valid = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL rr_timeout got %0d accesses exp 4", log_n - start); end
    // RX was served last, so TX wins the first contested decision.
    for (int i = 0; i < 4; i++) begin
      checks++; if (acc_log[start + i].rw !== 1'(i % 2)) begin errors++; $display("FAIL rr_order%0d got rw=%b exp %b", i, acc_log[start + i].rw, 1'(i % 2)); end
      if (i > 0) begin
        checks++; if (acc_log[start + i].cyc - acc_log[start + i - 1].cyc < 3) begin errors++; $display("FAIL rr_gap%0d got %0d exp >=3", i, acc_log[start + i].cyc - acc_log[start + i - 1].cyc); end
      end
    end
    tick(40);
    checks++; if (rx_valid !== 1'b0 || rx_head !== rx_tail) begin errors++; $display("FAIL rr_drain got %b/%0d exp 0/0", rx_valid, rx_tail - rx_head); end
    rx_ready = 1'b0;
  endtask

  task automatic test_baud_change;
    bit ok;
    int start;
    start = log_n;
    baud_sel = 2'b11;
    tick(1);
    checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL baud_cfg_clr got %b exp 0", cfg_done); end
    wait_log(start + 2, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL baud_timeout got %0d exp 2", log_n - start); end
    checks++; if ({acc_log[start].rw, acc_log[start].addr, acc_log[start].data} !== 11'b0_10_01010000) begin errors++; $display("FAIL baud_lo got %b/%h exp 10/50", acc_log[start].addr, acc_log[start].data); end
    checks++; if ({acc_log[start + 1].rw, acc_log[start + 1].addr, acc_log[start + 1].data} !== 11'b0_11_00000000) begin errors++; $display("FAIL baud_hi got %b/%h exp 11/00", acc_log[start + 1].addr, acc_log[start + 1].data); end
    tick(2);
    checks++; if (cfg_done !== 1'b1) begin errors++; $display("FAIL baud_cfg_set got %b exp 1", cfg_done); end
  endtask

  task automatic test_baud_mid_tx;
    bit ok;
    int start;
    start = log_n;
    tx_data = 8'h96;
    tx_valid = 1'b1;
    wait_txr(20, ok);
    baud_sel = 2'b00;
    tx_valid = 1'b0;
    checks++; if (!ok || databus !== 8'h96) begin errors++; $display("FAIL mid_tx got %h exp 96", databus); end
    checks++; if (cfg_done !== 1'b1) begin errors++; $display("FAIL mid_cfg_early got %b exp 1", cfg_done); end
    wait_log(start + 3, 30, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_timeout got %0d exp 3", log_n - start); end
    checks++; if ({acc_log[start + 1].addr, acc_log[start + 1].data} !== 10'b10_10001010) begin errors++; $display("FAIL mid_lo got %b/%h exp 10/8a", acc_log[start + 1].addr, acc_log[start + 1].data); end
    checks++; if ({acc_log[start + 2].addr, acc_log[start + 2].data} !== 10'b11_00000010) begin errors++; $display("FAIL mid_hi got %b/%h exp 11/02", acc_log[start + 2].addr, acc_log[start + 2].data); end
    tick(3);
    checks++; if (cfg_done !== 1'b1) begin errors++; $display("FAIL mid_cfg_done got %b exp 1", cfg_done); end
  endtask

`ifdef SPART_ECHO_EN
  task automatic test_echo;
    bit ok;
    int start;
    start = log_n;
    tbr = 1'b1;
    push_rx(8'h55);
    wait_log(start + 1, 30, ok);
    tx_data = 8'h99;
    tx_valid = 1'b1;
    checks++; if (!ok || acc_log[start].rw !== 1'b1 || acc_log[start].data !== 8'h55) begin errors++; $display("FAIL echo_rd got %b/%h exp 1/55", acc_log[start].rw, acc_log[start].data); end
    wait_log(start + 3, 40, ok);
    tx_valid = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL echo_timeout got %0d exp 3", log_n - start); end
    checks++; if ({acc_log[start + 1].rw, acc_log[start + 1].data, acc_log[start + 1].txr} !== 10'b0_01010101_0) begin errors++; $display("FAIL echo_wr got %b/%h/%b exp 0/55/0", acc_log[start + 1].rw, acc_log[start + 1].data, acc_log[start + 1].txr); end
    checks++; if ({acc_log[start + 2].rw, acc_log[start + 2].data, acc_log[start + 2].txr} !== 10'b0_10011001_1) begin errors++; $display("FAIL echo_tx got %b/%h/%b exp 0/99/1", acc_log[start + 2].rw, acc_log[start + 2].data, acc_log[start + 2].txr); end
    checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h55) begin errors++; $display("FAIL echo_fifo got %b/%h exp 1/55", rx_valid, rx_data); end
    rx_ready = 1'b1; tick(1); rx_ready = 1'b0;
  endtask
`endif

  task automatic test_reset_mid;
    bit seen;
    tbr = 1'b0;
    push_rx(8'h42);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(1);
      seen = rx_valid;
    end
    checks++; if (!seen) begin errors++; $display("FAIL rmid_fill got %b exp 1", rx_valid); end
    rst = 1'b1;
    tick(1);
    checks++; if ({rx_valid, cfg_done, iocs} !== 3'b000) begin errors++; $display("FAIL rmid_state got %b exp 000", {rx_valid, cfg_done, iocs}); end
    rst = 1'b0;
    tick(1);
    checks++; if ({iocs, iorw, ioaddr} !== 4'b1010 || databus !== 8'h8A) begin errors++; $display("FAIL rmid_cfg got %b/%h exp 1010/8a", {iocs, iorw, ioaddr}, databus); end
    tick(4);
    checks++; if (cfg_done !== 1'b1 || rx_valid !== 1'b0) begin errors++; $display("FAIL rmid_done got %b/%b exp 1/0", cfg_done, rx_valid); end
  endtask

  initial begin
    test_reset();
    test_config();
    test_tx();
`ifndef SPART_ECHO_EN
    test_rx();
    test_back_to_back();
`endif
    test_baud_change();
    test_baud_mid_tx();
`ifdef SPART_ECHO_EN
    test_echo();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
